// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: per-stage write enables, bubble flushes, multi-cycle load-use stalls.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_haz,
    input  logic             redirect,
    input  logic             dmem_busy,
    input  logic             imem_busy,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             redirect_sel,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // The RUN cycle that sees the hazard is the first stall cycle; the counter covers the rest.
    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    state_t     r_state;
    logic [2:0] r_lu_cnt;
    logic       r_redirect_pend;

    state_t     w_next_state;
    logic [2:0] w_next_lu_cnt;
    logic       w_next_pend;
    logic       w_redirect_any;
    logic       w_lu_active;
    logic       w_flush_evt;
    logic       w_pc_we;
    logic       w_if_de_we;
    logic       w_de_ex_we;
    logic       w_ex_mem_we;
    logic       w_if_de_flush;
    logic       w_de_ex_flush;
    logic       w_redirect_sel;

    assign w_redirect_any = redirect | r_redirect_pend;
    // A load-use stall interrupted by a memory freeze resumes from MEM_WAIT with its count intact.
    assign w_lu_active    = (r_state == ST_LU_STALL) ||
                            ((r_state == ST_MEM_WAIT) && (r_lu_cnt != 3'd0));

    // State register, remaining load-use count and remembered redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RUN;
            r_lu_cnt        <= 3'd0;
            r_redirect_pend <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_lu_cnt        <= w_next_lu_cnt;
            r_redirect_pend <= w_next_pend;
        end
    end

    // Next-state and Mealy enables, resolved in priority order dmem > redirect > load-use > imem.
    always_comb begin
        w_next_state   = ST_RUN;
        w_next_lu_cnt  = r_lu_cnt;
        w_next_pend    = r_redirect_pend;
        w_flush_evt    = 1'b0;
        w_pc_we        = 1'b1;
        w_if_de_we     = 1'b1;
        w_de_ex_we     = 1'b1;
        w_ex_mem_we    = 1'b1;
        w_if_de_flush  = 1'b0;
        w_de_ex_flush  = 1'b0;
        w_redirect_sel = 1'b0;
        if (dmem_busy) begin
            w_pc_we      = 1'b0;
            w_if_de_we   = 1'b0;
            w_de_ex_we   = 1'b0;
            w_ex_mem_we  = 1'b0;
            w_next_state = ST_MEM_WAIT;
            if (redirect) begin
                w_next_pend = 1'b1;
            end else begin
                w_next_pend = r_redirect_pend;
            end
        end else if (w_redirect_any) begin
            w_redirect_sel = 1'b1;
            w_if_de_flush  = 1'b1;
            w_de_ex_flush  = 1'b1;
            w_flush_evt    = 1'b1;
            w_next_pend    = 1'b0;
            w_next_lu_cnt  = 3'd0;
            w_next_state   = ST_RUN;
        end else if (w_lu_active) begin
            w_pc_we       = 1'b0;
            w_if_de_we    = 1'b0;
            w_de_ex_flush = 1'b1;
            if (r_lu_cnt <= 3'd1) begin
                w_next_lu_cnt = 3'd0;
                w_next_state  = ST_RUN;
            end else begin
                w_next_lu_cnt = r_lu_cnt - 3'd1;
                w_next_state  = ST_LU_STALL;
            end
        end else if (load_use_haz) begin
            w_pc_we       = 1'b0;
            w_if_de_we    = 1'b0;
            w_de_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                w_next_lu_cnt = LU_INIT;
                w_next_state  = ST_LU_STALL;
            end else begin
                w_next_lu_cnt = 3'd0;
                w_next_state  = ST_RUN;
            end
        end else if (imem_busy) begin
            w_pc_we       = 1'b0;
            w_if_de_flush = 1'b1;
            w_next_state  = ST_RUN;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // Reset forces every stage to hold and bubbles into IF/DE and DE/EX.
    always_comb begin
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_de_flush  = 1'b1;
            de_ex_flush  = 1'b1;
            redirect_sel = 1'b0;
            stalled      = 1'b1;
        end else begin
            pc_we        = w_pc_we;
            if_de_we     = w_if_de_we;
            de_ex_we     = w_de_ex_we;
            ex_mem_we    = w_ex_mem_we;
            if_de_flush  = w_if_de_flush;
            de_ex_flush  = w_de_ex_flush;
            redirect_sel = w_redirect_sel;
            stalled      = (r_state != ST_RUN) ||
                           !(w_pc_we & w_if_de_we & w_de_ex_we & w_ex_mem_we);
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating stall and redirect-flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic w_unused_flush_evt;
    assign w_unused_flush_evt = w_flush_evt;
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized self-checking bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int LAT   = 3;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic haz = 1'b0, red = 1'b0, dm = 1'b0, im = 1'b0;
    logic pc_we, if_de_we, de_ex_we, ex_mem_we, if_de_flush, de_ex_flush, redirect_sel, stalled;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: stall cycles still owed, remembered redirect, previous cycle frozen, event totals.
    int     m_rem = 0;
    bit     m_pend = 1'b0;
    bit     m_prev_busy = 1'b0;
    longint m_stall = 0;
    longint m_flush = 0;

    typedef struct {
        logic pc, ifde, deex, exmem, fif, fde, sel, stl;
    } exp_t;

    pipe_stall_ctrl #(.LOAD_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_use_haz(haz), .redirect(red),
        .dmem_busy(dm), .imem_busy(im), .pc_we(pc_we), .if_de_we(if_de_we),
        .de_ex_we(de_ex_we), .ex_mem_we(ex_mem_we), .if_de_flush(if_de_flush),
        .de_ex_flush(de_ex_flush), .redirect_sel(redirect_sel), .stalled(stalled),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.pc = 1'b1; e.ifde = 1'b1; e.deex = 1'b1; e.exmem = 1'b1;
        e.fif = 1'b0; e.fde = 1'b0; e.sel = 1'b0;
        if (!rst_n) begin
            e.pc = 1'b0; e.ifde = 1'b0; e.deex = 1'b0; e.exmem = 1'b0;
            e.fif = 1'b1; e.fde = 1'b1;
        end else if (dm) begin
            e.pc = 1'b0; e.ifde = 1'b0; e.deex = 1'b0; e.exmem = 1'b0;
        end else if (red || m_pend) begin
            e.sel = 1'b1; e.fif = 1'b1; e.fde = 1'b1;
        end else if (m_rem > 0 || haz) begin
            e.pc = 1'b0; e.ifde = 1'b0; e.fde = 1'b1;
        end else if (im) begin
            e.pc = 1'b0; e.fif = 1'b1;
        end
        e.stl = !(e.pc && e.ifde && e.deex && e.exmem) || m_prev_busy || (m_rem > 0) || !rst_n;
        return e;
    endfunction

    // Advance the behavioural model on each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0; m_pend <= 1'b0; m_prev_busy <= 1'b0; m_stall <= 0; m_flush <= 0;
        end else begin
            if (!model_out().pc) m_stall <= m_stall + 1;
            if (dm) begin
                m_pend <= m_pend | red;
                m_prev_busy <= 1'b1;
            end else begin
                m_prev_busy <= 1'b0;
                if (red || m_pend) begin
                    m_pend <= 1'b0; m_rem <= 0; m_flush <= m_flush + 1;
                end else if (m_rem > 0) begin
                    m_rem <= m_rem - 1;
                end else if (haz) begin
                    m_rem <= LAT - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        e = model_out();
        chk("pc_we", 64'(pc_we), 64'(e.pc));
        chk("if_de_we", 64'(if_de_we), 64'(e.ifde));
        chk("de_ex_we", 64'(de_ex_we), 64'(e.deex));
        chk("ex_mem_we", 64'(ex_mem_we), 64'(e.exmem));
        chk("if_de_flush", 64'(if_de_flush), 64'(e.fif));
        chk("de_ex_flush", 64'(de_ex_flush), 64'(e.fde));
        chk("redirect_sel", 64'(redirect_sel), 64'(e.sel));
        chk("stalled", 64'(stalled), 64'(e.stl));
`ifdef PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
        chk("stall_cnt", 64'(stall_cnt), 64'd0);
        chk("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    endtask

    task automatic step(input logic h, input logic r, input logic d, input logic i);
        @(posedge clk);
        #1;
        haz = h; red = r; dm = d; im = i;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int pcz;
        int dexf;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc_we", 64'(pc_we), 64'd0);
        chk("reset_flush", 64'({if_de_flush, de_ex_flush}), 64'd3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_we", 64'({pc_we, if_de_we, de_ex_we, ex_mem_we}), 64'hF);
        chk("idle_stalled", 64'(stalled), 64'd0);

        // Single load-use pulse: exactly LAT stall cycles.
        pcz = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0); pcz += int'(!pc_we);
        for (int k = 0; k < LAT; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0); pcz += int'(!pc_we);
        end
        chk("lu_stall_len", 64'(pcz), 64'(LAT));
        chk("lu_after_pc_we", 64'(pc_we), 64'd1);

        // Redirect overrides a same-cycle load-use hazard.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("redir_sel", 64'({redirect_sel, pc_we, if_de_flush, de_ex_flush}), 64'hF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("redir_no_stall", 64'(stalled), 64'd0);

        // Redirect arriving during a 3-cycle memory freeze is applied afterwards.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("freeze_we", 64'({pc_we, if_de_we, de_ex_we, ex_mem_we}), 64'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("freeze3_sel", 64'(redirect_sel), 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pend_applied", 64'({redirect_sel, if_de_flush, de_ex_flush}), 64'h7);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pend_cleared", 64'({redirect_sel, stalled}), 64'h0);

        // Memory freeze inside a load-use stall extends it by the freeze length.
        pcz = 0; dexf = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0); pcz += int'(!pc_we); dexf += int'(de_ex_flush);
        step(1'b0, 1'b0, 1'b0, 1'b0); pcz += int'(!pc_we); dexf += int'(de_ex_flush);
        step(1'b0, 1'b0, 1'b1, 1'b0); pcz += int'(!pc_we); dexf += int'(de_ex_flush);
        step(1'b0, 1'b0, 1'b1, 1'b0); pcz += int'(!pc_we); dexf += int'(de_ex_flush);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0); pcz += int'(!pc_we); dexf += int'(de_ex_flush);
        end
        chk("lu_frozen_pc_stall", 64'(pcz), 64'(LAT + 2));
        chk("lu_frozen_bubbles", 64'(dexf), 64'(LAT));

        // Instruction fetch miss alone.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("imem_only", 64'({pc_we, if_de_we, de_ex_we, ex_mem_we, if_de_flush, de_ex_flush}), 64'b011110);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0);
        end

        // Asynchronous reset mid-cycle takes effect immediately.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_pc_we", 64'(pc_we), 64'd0);
        chk("async_rst_flush", 64'({if_de_flush, de_ex_flush, redirect_sel}), 64'b110);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1 rst_n = 1'b1; haz = 1'b0; red = 1'b0; dm = 1'b0; im = 1'b0;
        @(negedge clk);
        compare_all();
        chk("post_rst_idle", 64'({pc_we, if_de_we, de_ex_we, ex_mem_we, if_de_flush, de_ex_flush}), 64'b111100);

        // Counter tally: one load-use (LAT stalls), two redirects, one fetch miss.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < LAT - 1; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PERF_CNT_EN
        chk("perf_stall_cnt", 64'(stall_cnt), 64'(LAT + 1));
        chk("perf_flush_cnt", 64'(flush_cnt), 64'd2);
`else
        chk("perf_off_cnts", 64'({stall_cnt, flush_cnt}), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline stall/flush controller for the 5-stage core. It consumes the hazard unit's load-use request plus branch/jump redirect and memory-busy indications. It drives per-stage register write enables (pc, IF/DE, DE/EX, EX/MEM) and bubble-insert flushes. It holds multi-cycle stall state and remembers a redirect that arrives while the pipeline is frozen.

Parameters:
LOAD_LAT, 1, total load-use stall cycles per hazard (1..7)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
load_use_haz  in  1  load-use hazard request from the hazard unit (DE consumer of EX load)
redirect  in  1  branch taken or jal/jalr resolved in EX; PC loads target when pc_we=1
dmem_busy  in  1  data memory not ready for the instruction in MEM
imem_busy  in  1  instruction memory not ready for the fetch in IF
pc_we  out  1  PC register enable
if_de_we  out  1  IF/DE register enable
de_ex_we  out  1  DE/EX register enable
ex_mem_we  out  1  EX/MEM register enable
if_de_flush  out  1  load NOP into IF/DE
de_ex_flush  out  1  load NOP into DE/EX
redirect_sel  out  1  PC mux selects EX target (live or pending redirect)
stalled  out  1  state != RUN or any enable low
stall_cnt  out  CNT_W  stall cycles (PERF_CNT_EN only)
flush_cnt  out  CNT_W  redirect flush events (PERF_CNT_EN only)

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Register lu_cnt (3 bits) and redirect_pend (1 bit).
- rst_n=0, async: state=RUN, lu_cnt=0, redirect_pend=0, counters=0. While asserted: all *_we=0, if_de_flush=de_ex_flush=1, redirect_sel=0.
- Outputs are Mealy on state + inputs. Default is all we=1, flushes=0, redirect_sel=0.
- Priority each cycle: dmem_busy > redirect/redirect_pend > load_use_haz > imem_busy.
- dmem_busy=1 (any state): all four we=0, no flush.
  - If redirect=1 the same cycle, set redirect_pend=1.
  - Next state is MEM_WAIT. Any LU_STALL progress is frozen; lu_cnt is held.
- MEM_WAIT, dmem_busy=0: the cycle is evaluated as RUN with the lower-priority rules, using redirect OR redirect_pend. Exit to RUN, or resume LU_STALL if lu_cnt!=0.
- Redirect (live or pending, not dmem_busy):
  - redirect_sel=1, pc_we=1, if_de_flush=1, de_ex_flush=1.
  - Clears redirect_pend and lu_cnt, next=RUN.
  - Overrides load_use_haz and imem_busy (wrong-path instructions are discarded).
- load_use_haz in RUN, no redirect: pc_we=0, if_de_we=0, de_ex_flush=1, ex_mem_we=1.
  - If LOAD_LAT>1: lu_cnt=LOAD_LAT-1, next=LU_STALL.
- LU_STALL: same stall outputs regardless of load_use_haz. lu_cnt decrements each non-frozen cycle; when it reaches 1, next=RUN.
- imem_busy only: pc_we=0, if_de_flush=1, other we=1.
- Total load-use stall is exactly LOAD_LAT cycles excluding MEM_WAIT freeze cycles.
- stalled=1 whenever any we=0 or state!=RUN.

Optional Feature:
PERF_CNT_EN:
- Defined: stall_cnt increments every cycle with pc_we=0. flush_cnt increments every cycle a redirect flush is applied. Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset: rst_n=0 mid-run -> pc_we=0, if_de_flush=de_ex_flush=1 immediately; after release at idle inputs, all we=1, flushes=0.
- LOAD_LAT=2, load_use_haz=1 one cycle -> pc_we=0, if_de_we=0, de_ex_flush=1 for exactly 2 cycles, then all we=1.
- redirect=1 with load_use_haz=1 same cycle -> redirect_sel=1, pc_we=1, both flushes=1, no stall next cycle.
- dmem_busy=1 for 3 cycles with redirect=1 in the first -> all we=0 for 3 cycles; 4th cycle redirect_sel=1, both flushes=1; redirect_pend=0 afterward.
- LOAD_LAT=3, dmem_busy pulse during LU_STALL -> stall output cycles = 3 + busy cycles; lu_cnt frozen during busy.
- PERF_CNT_EN: 1 load-use (LOAD_LAT=1) + 2 redirects + 1 imem_busy -> stall_cnt=2, flush_cnt=2.
